// File: rtl/hk_spi_passthru_if.sv
// Host-side SPI pin bundle for the housekeeping SPI slave.
// The slave modport is the device view; the master modport is the host view.
interface hk_spi_passthru_if;
  logic sck;
  logic csb;
  logic sdi;
  logic sdo;
  logic sdo_oeb;

  modport slave  (input sck, csb, sdi, output sdo, sdo_oeb);
  modport master (output sck, csb, sdi, input sdo, sdo_oeb);
endinterface

// File: rtl/hk_spi_passthru.sv
// Housekeeping SPI slave: oversampled mode-0 register access to a small ID/control
// file, plus a pass-thru mode that hands the host SPI pins to the management flash.
module hk_spi_passthru #(
  parameter logic [11:0] MFGR_ID    = 12'h456,
  parameter logic [7:0]  PRODUCT_ID = 8'h20,
  parameter logic [31:0] PROJECT_ID = 32'h0
) (
  input  logic              clock,
  input  logic              resetb,
  hk_spi_passthru_if.slave  spi,
  input  logic              mgmt_flash_csb,
  input  logic              mgmt_flash_clk,
  input  logic              mgmt_flash_io0,
  output logic              mgmt_flash_io1,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_io0,
  input  logic              flash_io1,
  output logic              cpu_reset
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COMMAND  = 3'd1,
    ST_ADDRESS  = 3'd2,
    ST_DATA     = 3'd3,
    ST_PASSTHRU = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        sck_meta_r, sck_sync_r, sck_prev_r;
  logic        csb_meta_r, csb_sync_r;
  logic        sdi_meta_r, sdi_sync_r;
  logic        sck_rise_s, sck_fall_s, byte_done_s, cmd_pt_s;
  logic [2:0]  bit_cnt_r;
  logic [6:0]  in_shift_r;
  logic [7:0]  data_byte_s;
  logic [7:0]  out_shift_r;
  logic [7:0]  addr_r;
  logic [7:0]  addr_next_s;
  logic        rd_mode_r, wr_mode_r;
  logic        sdo_r, sdo_oeb_r;
  logic        passthru_r, pt_reset_r;
  logic [7:0]  scratch_r;
  logic        cpu_reset_reg_r;

  function automatic logic [7:0] reg_read(input logic [7:0] a, input logic [7:0] scratch,
                                          input logic cpu_rst);
    case (a)
      8'h00:   reg_read = 8'h00;
      8'h01:   reg_read = {4'h0, MFGR_ID[11:8]};
      8'h02:   reg_read = MFGR_ID[7:0];
      8'h03:   reg_read = PRODUCT_ID;
      8'h04:   reg_read = PROJECT_ID[31:24];
      8'h05:   reg_read = PROJECT_ID[23:16];
      8'h06:   reg_read = PROJECT_ID[15:8];
      8'h07:   reg_read = PROJECT_ID[7:0];
      8'h08:   reg_read = scratch;
      8'h0B:   reg_read = {7'h00, cpu_rst};
      default: reg_read = 8'h00;
    endcase
  endfunction

  assign sck_rise_s  = sck_sync_r & ~sck_prev_r;
  assign sck_fall_s  = ~sck_sync_r & sck_prev_r;
  assign byte_done_s = sck_rise_s & (bit_cnt_r == 3'd7);
  assign data_byte_s = {in_shift_r, sdi_sync_r};
  assign addr_next_s = addr_r + 8'd1;
  assign cmd_pt_s    = ~csb_sync_r & byte_done_s & (state_r == ST_COMMAND) &
                       (data_byte_s == 8'hC4);

  // Two-stage synchronizers for the host pins plus the SCK edge-detect history.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_meta_r <= 1'b0;
      sck_sync_r <= 1'b0;
      sck_prev_r <= 1'b0;
      csb_meta_r <= 1'b1;
      csb_sync_r <= 1'b1;
      sdi_meta_r <= 1'b0;
      sdi_sync_r <= 1'b0;
    end else begin
      sck_meta_r <= spi.sck;
      sck_sync_r <= sck_meta_r;
      sck_prev_r <= sck_sync_r;
      csb_meta_r <= spi.csb;
      csb_sync_r <= csb_meta_r;
      sdi_meta_r <= spi.sdi;
      sdi_sync_r <= sdi_meta_r;
    end
  end

  // Transaction state register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a deasserted chip select always returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    if (csb_sync_r) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_COMMAND;
        ST_COMMAND: begin
          if (byte_done_s) begin
            case (data_byte_s)
              8'h80, 8'h40, 8'hC0: state_next_s = ST_ADDRESS;
              8'hC4:               state_next_s = ST_PASSTHRU;
              default:             state_next_s = ST_IGNORE;
            endcase
          end else begin
            state_next_s = state_r;
          end
        end
        ST_ADDRESS: begin
          if (byte_done_s) begin
            state_next_s = ST_DATA;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_DATA, ST_PASSTHRU, ST_IGNORE: state_next_s = state_r;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Bit/byte datapath: shift in on SCK rise, shift out on SCK fall, register file writes.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      bit_cnt_r       <= 3'd0;
      in_shift_r      <= 7'h00;
      out_shift_r     <= 8'h00;
      addr_r          <= 8'h00;
      rd_mode_r       <= 1'b0;
      wr_mode_r       <= 1'b0;
      sdo_r           <= 1'b0;
      sdo_oeb_r       <= 1'b1;
      passthru_r      <= 1'b0;
      scratch_r       <= 8'h00;
      cpu_reset_reg_r <= 1'b0;
    end else if (csb_sync_r) begin
      // Any partial byte is dropped here, so an aborted write never commits.
      bit_cnt_r  <= 3'd0;
      rd_mode_r  <= 1'b0;
      wr_mode_r  <= 1'b0;
      sdo_r      <= 1'b0;
      sdo_oeb_r  <= 1'b1;
      passthru_r <= 1'b0;
    end else if (sck_rise_s) begin
      in_shift_r <= data_byte_s[6:0];
      bit_cnt_r  <= bit_cnt_r + 3'd1;
      if (bit_cnt_r == 3'd7) begin
        case (state_r)
          ST_COMMAND: begin
            rd_mode_r  <= (data_byte_s == 8'h40) || (data_byte_s == 8'hC0);
            wr_mode_r  <= (data_byte_s == 8'h80) || (data_byte_s == 8'hC0);
            passthru_r <= (data_byte_s == 8'hC4);
          end
          ST_ADDRESS: begin
            addr_r <= data_byte_s;
            if (rd_mode_r) begin
              out_shift_r <= reg_read(data_byte_s, scratch_r, cpu_reset_reg_r);
              sdo_oeb_r   <= 1'b0;
            end
          end
          ST_DATA: begin
            if (wr_mode_r && (addr_r == 8'h08)) begin
              scratch_r <= data_byte_s;
            end
            if (wr_mode_r && (addr_r == 8'h0B)) begin
              cpu_reset_reg_r <= data_byte_s[0];
            end
            addr_r <= addr_next_s;
            // The next byte is preloaded before this byte's write lands, so read+write
            // returns the pre-write contents.
            if (rd_mode_r) begin
              out_shift_r <= reg_read(addr_next_s, scratch_r, cpu_reset_reg_r);
            end
          end
          default: begin
            addr_r <= addr_r;
          end
        endcase
      end
    end else if (sck_fall_s && (state_r == ST_DATA) && rd_mode_r) begin
      sdo_r       <= out_shift_r[7];
      out_shift_r <= {out_shift_r[6:0], 1'b0};
    end
  end

  // CPU hold for pass-thru: set on entry, released one clock after pass-thru ends.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      pt_reset_r <= 1'b0;
    end else if (cmd_pt_s) begin
      pt_reset_r <= 1'b1;
    end else if (!passthru_r) begin
      pt_reset_r <= 1'b0;
    end
  end

  assign flash_csb      = passthru_r ? csb_sync_r : mgmt_flash_csb;
  assign flash_clk      = passthru_r ? sck_sync_r : mgmt_flash_clk;
  assign flash_io0      = passthru_r ? sdi_sync_r : mgmt_flash_io0;
  assign mgmt_flash_io1 = flash_io1;
  assign spi.sdo        = passthru_r ? flash_io1 : sdo_r;
  assign spi.sdo_oeb    = passthru_r ? 1'b0 : sdo_oeb_r;
  assign cpu_reset      = pt_reset_r | cpu_reset_reg_r;

endmodule

// File: tb/tb_hk_spi_passthru.sv
// Bench for hk_spi_passthru: a host SPI driver, a small SPI flash model and a
// scoreboard of expected read bytes checked by an independent monitor.
module tb_hk_spi_passthru;
  logic clock = 1'b0;
  logic resetb = 1'b0;
  always #5 clock = ~clock;

  hk_spi_passthru_if spi ();
  logic mgmt_flash_csb, mgmt_flash_clk, mgmt_flash_io0, mgmt_flash_io1;
  logic flash_csb, flash_clk, flash_io0, flash_io1, cpu_reset;

  hk_spi_passthru dut (
    .clock          (clock),
    .resetb         (resetb),
    .spi            (spi),
    .mgmt_flash_csb (mgmt_flash_csb),
    .mgmt_flash_clk (mgmt_flash_clk),
    .mgmt_flash_io0 (mgmt_flash_io0),
    .mgmt_flash_io1 (mgmt_flash_io1),
    .flash_csb      (flash_csb),
    .flash_clk      (flash_clk),
    .flash_io0      (flash_io0),
    .flash_io1      (flash_io1),
    .cpu_reset      (cpu_reset)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_data;
  event rx_ev;

  // SPI flash model: mode 0, 8-bit command + 24-bit address, then streams data.
  logic [7:0] fmem [0:7] = '{8'h6F, 8'h00, 8'h00, 8'h0B, 8'h13, 8'h00, 8'h00, 8'h00};
  logic [7:0] pt_exp [0:7] = '{8'h6F, 8'h00, 8'h00, 8'h0B, 8'h13, 8'h00, 8'h00, 8'h00};
  logic fclk_prev = 1'b0;
  logic fcsb_prev = 1'b1;
  logic fio1 = 1'b0;
  int fcnt = 0;
  logic [31:0] fcmd = 32'h0;
  assign flash_io1 = fio1;

  function automatic logic flash_bit(input int pos, input logic [2:0] base);
    logic [2:0] idx;
    logic [7:0] b;
    idx = base + 3'(pos / 8);
    b = fmem[idx];
    return b[3'(7 - (pos % 8))];
  endfunction

  always @(posedge clock) begin
    if (flash_csb) begin
      fcnt <= 0;
      fio1 <= 1'b0;
    end else if (!fcsb_prev) begin
      if (flash_clk && !fclk_prev) begin
        if (fcnt < 32) fcmd <= {fcmd[30:0], flash_io0};
        fcnt <= fcnt + 1;
      end else if (!flash_clk && fclk_prev && fcnt >= 32) begin
        fio1 <= flash_bit(fcnt - 32, fcmd[2:0]);
      end
    end
    fclk_prev <= flash_clk;
    fcsb_prev <= flash_csb;
  end

  // Scoreboard monitor: each completed host read byte is matched against the queue.
  initial begin
    logic [7:0] exp;
    forever begin
      @(rx_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected actual=%02h expected=<none>", rx_data);
      end else begin
        exp = exp_q.pop_front();
        if (rx_data !== exp) begin
          errors++;
          $display("FAIL rx_byte actual=%02h expected=%02h", rx_data, exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi.sdi = tx[3'(7 - i)];
      wait_clk(8);
      rx = {rx[6:0], spi.sdo};
      spi.sck = 1'b1;
      wait_clk(8);
      spi.sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] d;
    xfer(tx, 8, d);
  endtask

  task automatic rw_byte(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] r;
    exp_q.push_back(exp);
    xfer(tx, 8, r);
    rx_data = r;
    ->rx_ev;
  endtask

  task automatic cs_low();
    spi.csb = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(8);
    spi.csb = 1'b1;
    wait_clk(8);
  endtask

  task automatic read_reg(input logic [7:0] addr, input logic [7:0] exp);
    cs_low();
    send(8'h40);
    send(addr);
    rw_byte(8'h00, exp);
    cs_high();
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] val);
    cs_low();
    send(8'h80);
    send(addr);
    send(val);
    cs_high();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    spi.sck = 1'b0;
    spi.csb = 1'b1;
    spi.sdi = 1'b0;
    mgmt_flash_csb = 1'b1;
    mgmt_flash_clk = 1'b0;
    mgmt_flash_io0 = 1'b0;
    wait_clk(3);
    check("reset_oeb", 32'(spi.sdo_oeb), 32'd1);
    check("reset_sdo", 32'(spi.sdo), 32'd0);
    check("reset_cpu_reset", 32'(cpu_reset), 32'd0);
    check("reset_flash_csb", 32'(flash_csb), 32'd1);
    resetb = 1'b1;
    wait_clk(4);

    // Single-byte ID read
    cs_low();
    send(8'h40);
    send(8'h03);
    rw_byte(8'h00, 8'h20);
    check("read_oeb_driven", 32'(spi.sdo_oeb), 32'd0);
    cs_high();
    check("idle_oeb", 32'(spi.sdo_oeb), 32'd1);
    check("idle_sdo", 32'(spi.sdo), 32'd0);

    // Streamed read with auto-increment
    cs_low();
    send(8'h40);
    send(8'h01);
    rw_byte(8'h00, 8'h04);
    rw_byte(8'h00, 8'h56);
    rw_byte(8'h00, 8'h20);
    cs_high();

    // Address wrap 0xFF -> 0x00 -> 0x01
    cs_low();
    send(8'h40);
    send(8'hFF);
    rw_byte(8'h00, 8'h00);
    rw_byte(8'h00, 8'h00);
    rw_byte(8'h00, 8'h04);
    cs_high();

    // Scratch write, readback, read+write returns old value
    write_reg(8'h08, 8'hA5);
    read_reg(8'h08, 8'hA5);
    cs_low();
    send(8'hC0);
    send(8'h08);
    rw_byte(8'h3C, 8'hA5);
    cs_high();
    read_reg(8'h08, 8'h3C);
    read_reg(8'h07, 8'h00);

    // CPU reset control register
    write_reg(8'h0B, 8'h01);
    check("cpu_reset_reg_set", 32'(cpu_reset), 32'd1);
    read_reg(8'h0B, 8'h01);
    write_reg(8'h0B, 8'h00);
    check("cpu_reset_reg_clr", 32'(cpu_reset), 32'd0);

    // Unknown command is ignored
    cs_low();
    send(8'h11);
    send(8'h08);
    xfer(8'hFF, 8, d);
    check("ignore_oeb", 32'(spi.sdo_oeb), 32'd1);
    check("ignore_sdo", 32'(spi.sdo), 32'd0);
    cs_high();
    read_reg(8'h08, 8'h3C);

    // Chip select raised mid-byte drops the partial write
    cs_low();
    send(8'h80);
    send(8'h08);
    xfer(8'h00, 5, d);
    cs_high();
    read_reg(8'h08, 8'h3C);

    // Pass-thru flash read
    check("pre_pt_flash_csb", 32'(flash_csb), 32'd1);
    cs_low();
    send(8'hC4);
    check("pt_cpu_reset", 32'(cpu_reset), 32'd1);
    check("pt_flash_csb_low", 32'(flash_csb), 32'd0);
    check("pt_oeb", 32'(spi.sdo_oeb), 32'd0);
    send(8'h03);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    for (int i = 0; i < 8; i++) begin
      rw_byte(8'h00, pt_exp[i]);
      check("pt_cpu_reset_hold", 32'(cpu_reset), 32'd1);
    end
    check("pt_mgmt_io1", 32'(mgmt_flash_io1), 32'(fio1));
    wait_clk(8);
    spi.csb = 1'b1;
    wait_clk(5);
    check("exit_flash_csb", 32'(flash_csb), 32'd1);
    check("exit_cpu_reset", 32'(cpu_reset), 32'd0);
    check("exit_oeb", 32'(spi.sdo_oeb), 32'd1);
    mgmt_flash_clk = 1'b1;
    mgmt_flash_io0 = 1'b1;
    wait_clk(1);
    check("exit_flash_clk", 32'(flash_clk), 32'd1);
    check("exit_flash_io0", 32'(flash_io0), 32'd1);
    mgmt_flash_clk = 1'b0;
    mgmt_flash_io0 = 1'b0;
    wait_clk(8);
    read_reg(8'h03, 8'h20);

    // Async reset in the middle of pass-thru
    cs_low();
    send(8'hC4);
    check("pt2_cpu_reset", 32'(cpu_reset), 32'd1);
    wait_clk(2);
    resetb = 1'b0;
    wait_clk(1);
    check("rst_pt_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_pt_flash_csb", 32'(flash_csb), 32'd1);
    check("rst_pt_oeb", 32'(spi.sdo_oeb), 32'd1);
    wait_clk(2);
    resetb = 1'b1;
    wait_clk(4);
    spi.csb = 1'b1;
    wait_clk(8);
    read_reg(8'h08, 8'h00);

    wait_clk(20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
